// File: rtl/counter_step_ctrl_pkg.sv
// Shared types and constants for the counter step front-end.
//   state_e   : controller FSM states
//   DIR_*     : encoding of owner_dn (0 = up, 1 = down)
//   BTN_*     : lane index of each button in the debounce array
//   btn_evt_t : per-button rise/fall strobes from the debouncer
//   cnt_w()   : counter width needed to hold values 0..n-1
package counter_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_UP = 2'd1,
    ST_OWN_DN = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int NUM_BTN = 2;
  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;

  typedef struct packed {
    logic rise;
    logic fall;
  } btn_evt_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_step_ctrl_if.sv
// Button / step bus between the push-button side and the controller.
//   push1, push2 : raw asynchronous up / down buttons (active high)
//   step_up/dn   : one-cycle step requests to the counter
//   busy         : a button currently owns the controller
//   owner_dn     : direction of the current or last grant
interface counter_step_ctrl_if;
  logic push1;
  logic push2;
  logic step_up;
  logic step_dn;
  logic busy;
  logic owner_dn;

  modport master (
    output push1, push2,
    input  step_up, step_dn, busy, owner_dn
  );

  modport slave (
    input  push1, push2,
    output step_up, step_dn, busy, owner_dn
  );
endinterface

// File: rtl/counter_step_ctrl_debounce.sv
// button_debounce: one button lane.
//   clk, rst_n : clock, async active-low reset
//   btn_i      : raw asynchronous button level
//   evt_o      : registered rise/fall strobes of the debounced level
// A 2-flop synchroniser feeds a counter that must see DEBOUNCE_CYCLES
// consecutive differing samples before the stable level flips.
module button_debounce
  import counter_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     btn_i,
  output btn_evt_t evt_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          s_sync;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, fall_q;

  assign s_sync = sync_q[1];

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (s_sync == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      // last differing sample of the window: accept the new level
      lvl_d = s_sync;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end

  assign evt_o.rise = rise_q;
  assign evt_o.fall = fall_q;

endmodule

// File: rtl/counter_step_ctrl.sv
// counter_step_ctrl: debounced, arbitrated, auto-repeating step generator
// for the 3-bit up/down counter.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of counter_step_ctrl_if (buttons in, steps out)
// Each physical press yields one step pulse; holding the owning button
// repeats after REPEAT_DELAY then every REPEAT_PERIOD cycles.
module counter_step_ctrl
  import counter_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_step_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] OWN_UP = ST_OWN_UP;
  localparam logic [1:0] OWN_DN = ST_OWN_DN;

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = cnt_w(TMAX);

  logic [NUM_BTN-1:0] push;
  btn_evt_t [NUM_BTN-1:0] evt;

  assign push[BTN_UP] = bus.push1;
  assign push[BTN_DN] = bus.push2;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (push[g]),
      .evt_o (evt[g])
    );
  end

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          first_q, first_d;   // next repeat is the initial (long) one
  logic          owner_q, owner_d;
  logic          step_up_q, step_up_d;
  logic          step_dn_q, step_dn_d;
  logic          busy_q;
  logic          rpt_due;
  logic          own_fall;

  assign rpt_due = (REPEAT_EN != 0) &&
                   (tmr_q == (first_q ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_PERIOD - 1)));

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    first_d   = first_q;
    owner_d   = owner_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    own_fall  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d   = '0;
        first_d = 1'b1;
        // simultaneous rises go to the direction that did not win last
        if (evt[BTN_UP].rise && (!evt[BTN_DN].rise || owner_q == DIR_DN)) begin
          state_d   = OWN_UP;
          step_up_d = 1'b1;
          owner_d   = DIR_UP;
        end else if (evt[BTN_DN].rise) begin
          state_d   = OWN_DN;
          step_dn_d = 1'b1;
          owner_d   = DIR_DN;
        end
      end
      OWN_UP, OWN_DN: begin
        // the other button's edges are ignored while owned
        own_fall = (state_q == OWN_UP) ? evt[BTN_UP].fall : evt[BTN_DN].fall;
        if (own_fall) begin
          state_d = IDLE;
          tmr_d   = '0;
          first_d = 1'b1;
        end else if (rpt_due) begin
          step_up_d = (state_q == OWN_UP);
          step_dn_d = (state_q == OWN_DN);
          tmr_d     = '0;
          first_d   = 1'b0;
        end else if (REPEAT_EN != 0) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
        first_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      first_q   <= 1'b1;
      owner_q   <= DIR_DN;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      first_q   <= first_d;
      owner_q   <= owner_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.step_up  = step_up_q;
  assign bus.step_dn  = step_dn_q;
  assign bus.busy     = busy_q;
  assign bus.owner_dn = owner_q;

endmodule

// File: tb/tb_counter_step_ctrl.sv
module tb_counter_step_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_step_ctrl_if bus();

  counter_step_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int ec, up_n, dn_n, both_n, busy_n;
  int up_at[$];
  int dn_at[$];
  logic busy_log [0:63];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    ec = 0; up_n = 0; dn_n = 0; both_n = 0; busy_n = 0;
    up_at.delete();
    dn_at.delete();
    for (int i = 0; i < 64; i++) busy_log[i] = 1'b0;
  endtask

  // advance n edges, sampling outputs 1 time unit after each edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ec++;
      if (ec < 64) busy_log[ec] = bus.busy;
      if (bus.busy) busy_n++;
      if (bus.step_up) begin up_n++; up_at.push_back(ec); end
      if (bus.step_dn) begin dn_n++; dn_at.push_back(ec); end
      if (bus.step_up && bus.step_dn) both_n++;
    end
  endtask

  function automatic int up_i(input int i);
    return (up_at.size() > i) ? up_at[i] : -1;
  endfunction

  function automatic int dn_i(input int i);
    return (dn_at.size() > i) ? dn_at[i] : -1;
  endfunction

  int pat [11] = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0};

  initial begin
    bus.push1 = 1'b0;
    bus.push2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up",    int'(bus.step_up),  0);
    chk("rst_dn",    int'(bus.step_dn),  0);
    chk("rst_busy",  int'(bus.busy),     0);
    chk("rst_owner", int'(bus.owner_dn), 1);
    rst_n = 1'b1;
    mark();
    step(4);

    // simultaneous press #1: up wins after reset
    mark();
    bus.push1 = 1'b1; bus.push2 = 1'b1;
    step(6);
    bus.push1 = 1'b0; bus.push2 = 1'b0;
    step(14);
    chk("sim1_up_n",  up_n, 1);
    chk("sim1_up_at", up_i(0), 7);
    chk("sim1_dn_n",  dn_n, 0);
    chk("sim1_owner", int'(bus.owner_dn), 0);
    chk("sim1_idle",  int'(bus.busy), 0);

    // simultaneous press #2: down wins
    mark();
    bus.push1 = 1'b1; bus.push2 = 1'b1;
    step(6);
    bus.push1 = 1'b0; bus.push2 = 1'b0;
    step(14);
    chk("sim2_dn_n",  dn_n, 1);
    chk("sim2_dn_at", dn_i(0), 7);
    chk("sim2_up_n",  up_n, 0);
    chk("sim2_owner", int'(bus.owner_dn), 1);

    // clean press and release
    mark();
    bus.push1 = 1'b1;
    step(6);
    bus.push1 = 1'b0;
    step(14);
    chk("clean_up_n",  up_n, 1);
    chk("clean_up_at", up_i(0), 7);
    chk("clean_dn_n",  dn_n, 0);
    chk("clean_busy6",  int'(busy_log[6]), 0);
    chk("clean_busy7",  int'(busy_log[7]), 1);
    chk("clean_busy12", int'(busy_log[12]), 1);
    chk("clean_busy13", int'(busy_log[13]), 0);

    // bounce on push2: runs of 1..3 cycles never settle
    mark();
    foreach (pat[i]) begin
      bus.push2 = pat[i][0];
      step(1);
    end
    bus.push2 = 1'b0;
    step(12);
    chk("bounce_dn_n",  dn_n, 0);
    chk("bounce_busy",  busy_n, 0);

    // hold push1 for repeats, push2 locked out, release on a repeat-due edge
    mark();
    bus.push1 = 1'b1;
    step(6);
    bus.push2 = 1'b1;
    step(18);
    bus.push1 = 1'b0;
    step(16);
    chk("rpt_up_n",  up_n, 5);
    chk("rpt_at0",   up_i(0), 7);
    chk("rpt_at1",   up_i(1), 15);
    chk("rpt_at2",   up_i(2), 19);
    chk("rpt_at3",   up_i(3), 23);
    chk("rpt_at4",   up_i(4), 27);
    chk("rpt_busy30", int'(busy_log[30]), 1);
    chk("rpt_busy31", int'(busy_log[31]), 0);
    bus.push2 = 1'b0;
    step(12);
    chk("rpt_dn_n",  dn_n, 0);
    chk("rpt_mutex", both_n, 0);

    // reset while a repeat pulse is on the bus
    mark();
    bus.push1 = 1'b1;
    step(19);
    chk("mid_up_n",   up_n, 3);
    chk("mid_pulse",  int'(bus.step_up), 1);
    chk("mid_owner0", int'(bus.owner_dn), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_up",    int'(bus.step_up),  0);
    chk("mid_rst_dn",    int'(bus.step_dn),  0);
    chk("mid_rst_busy",  int'(bus.busy),     0);
    chk("mid_rst_owner", int'(bus.owner_dn), 1);
    mark();
    step(6);
    chk("inrst_up_n",  up_n, 0);
    chk("inrst_busy",  busy_n, 0);

    // release reset with push1 still held: fresh grant then repeats
    mark();
    rst_n = 1'b1;
    step(20);
    chk("post_up_n",  up_n, 3);
    chk("post_at0",   up_i(0), 7);
    chk("post_at1",   up_i(1), 15);
    chk("post_at2",   up_i(2), 19);
    bus.push1 = 1'b0;
    step(12);
    chk("post_idle",  int'(bus.busy), 0);
    chk("post_mutex", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
